// File: rtl/program_loader.sv
// Host-side program loader: receives bytes over a slow asynchronous strobe handshake,
// writes them into the CPU program RAM, verifies a trailing checksum and gates the CPU reset.
module program_loader #(
  parameter int RAM_BYTES   = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              strobe,
  input  logic [7:0]        data_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              cksum_err,
  output logic              ack
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RAM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_strobe_sync;
  logic [SYNC_STAGES-1:0] r_load_sync;
  logic                   r_strobe_prev;
  logic                   r_load_prev;

  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_sum;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_we;
  logic              r_done;
  logic              r_err;
  logic              r_ack;

  logic       w_strobe_rise;
  logic       w_load_rise;
  logic       w_load_lvl;
  logic [7:0] w_sum_next;
  logic       w_write;
  logic       w_ack_toggle;
  logic       w_start;
  logic       w_set_done;
  logic       w_set_err;

  assign w_load_lvl    = r_load_sync[SYNC_STAGES-1];
  assign w_load_rise   = w_load_lvl & ~r_load_prev;
  assign w_strobe_rise = r_strobe_sync[SYNC_STAGES-1] & ~r_strobe_prev;
  assign w_sum_next    = r_sum + data_in;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_strobe_sync <= '0;
      r_load_sync   <= '0;
      r_strobe_prev <= 1'b0;
      r_load_prev   <= 1'b0;
    end else begin
      r_strobe_sync <= {r_strobe_sync[SYNC_STAGES-2:0], strobe};
      r_load_sync   <= {r_load_sync[SYNC_STAGES-2:0], load_req};
      r_strobe_prev <= r_strobe_sync[SYNC_STAGES-1];
      r_load_prev   <= w_load_lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    w_ack_toggle = 1'b0;
    w_start      = 1'b0;
    w_set_done   = 1'b0;
    w_set_err    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_load_rise) begin
          w_state_next = S_LOAD;
          w_start      = 1'b1;
        end
      end
      S_LOAD: begin
        // Host dropping load_req aborts, even if a byte arrives in the same cycle.
        if (!w_load_lvl) begin
          w_state_next = S_ERR;
          w_set_err    = 1'b1;
        end else if (w_strobe_rise) begin
          w_write      = 1'b1;
          w_ack_toggle = 1'b1;
          if (r_cnt == LAST_CNT) w_state_next = S_CKSUM;
        end
      end
      S_CKSUM: begin
        if (!w_load_lvl) begin
          w_state_next = S_ERR;
          w_set_err    = 1'b1;
        end else if (w_strobe_rise) begin
          w_ack_toggle = 1'b1;
          if (w_sum_next == 8'h00) begin
            w_state_next = S_DONE;
            w_set_done   = 1'b1;
          end else begin
            w_state_next = S_ERR;
            w_set_err    = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!w_load_lvl) w_state_next = S_IDLE;
      end
      S_ERR: begin
        if (w_load_rise) begin
          w_state_next = S_LOAD;
          w_start      = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_sum  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_ack  <= 1'b0;
    end else begin
      r_we <= w_write;
      if (w_start) begin
        r_cnt  <= '0;
        r_sum  <= '0;
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_write) begin
        r_addr <= r_cnt[ADDR_W-1:0];
        r_data <= data_in;
        r_sum  <= w_sum_next;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      if (w_ack_toggle) r_ack  <= ~r_ack;
      if (w_set_done)   r_done <= 1'b1;
      if (w_set_err)    r_err  <= 1'b1;
    end
  end

  assign ram_addr  = r_addr;
  assign ram_data  = r_data;
  assign ram_we    = r_we;
  assign done      = r_done;
  assign cksum_err = r_err;
  assign ack       = r_ack;
  assign busy      = (r_state == S_LOAD) || (r_state == S_CKSUM);
  assign cpu_rst_n = ~rst & (r_state == S_IDLE);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of load sessions plus random sessions, checked against
// expectations derived from the byte stream, with hand-written multi-cycle corner sequences.
module tb_program_loader;

  localparam int RAM_BYTES   = 16;
  localparam int ADDR_W      = 4;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_req;
  logic              strobe;
  logic [7:0]        data_in;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_we;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              cksum_err;
  logic              ack;

  always #5 clk = ~clk;

  program_loader #(
    .RAM_BYTES  (RAM_BYTES),
    .ADDR_W     (ADDR_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_req (load_req),
    .strobe   (strobe),
    .data_in  (data_in),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_we   (ram_we),
    .cpu_rst_n(cpu_rst_n),
    .busy     (busy),
    .done     (done),
    .cksum_err(cksum_err),
    .ack      (ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  typedef struct {
    bit ramp;
    int nbytes;
    bit send_ck;
    bit ck_good;
    bit exp_done;
    bit exp_err;
    int exp_we;
    int exp_ack;
  } vec_t;

  // Observed RAM writes and ack toggles
  wr_t  got_wr[$];
  int   ack_toggles = 0;
  int   we_double   = 0;
  logic ack_q       = 1'b0;
  logic we_q        = 1'b0;

  always @(negedge clk) begin
    wr_t w;
    if (ram_we === 1'b1) begin
      w.addr = ram_addr;
      w.data = ram_data;
      got_wr.push_back(w);
      if (we_q) we_double++;
    end
    if (ack !== ack_q) ack_toggles++;
    ack_q = ack;
    we_q  = (ram_we === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in = b;
    tick(1);
    strobe = 1'b1;
    tick(SYNC_STAGES + 3);
    strobe = 1'b0;
    tick(SYNC_STAGES + 3);
  endtask

  // Expected outcome of a session from its shape alone
  function automatic vec_t make_random();
    vec_t v;
    v.ramp     = 1'b0;
    v.nbytes   = $urandom_range(0, RAM_BYTES);
    v.send_ck  = (v.nbytes == RAM_BYTES) && ($urandom_range(0, 3) != 0);
    v.ck_good  = 1'($urandom_range(0, 1));
    v.exp_done = v.send_ck && v.ck_good;
    v.exp_err  = !v.exp_done;
    v.exp_we   = v.nbytes;
    v.exp_ack  = v.nbytes + (v.send_ck ? 1 : 0);
    return v;
  endfunction

  task automatic run_load(input string tag, input vec_t v);
    logic [7:0] bytes[$];
    logic [7:0] b;
    logic [7:0] sum;
    logic [7:0] ck;
    int         a;
    load_req = 1'b0;
    tick(SYNC_STAGES + 4);
    got_wr.delete();
    ack_toggles = 0;
    load_req = 1'b1;
    tick(SYNC_STAGES + 3);
    check({tag, " busy in load"}, busy, 1);
    check({tag, " cpu held"}, cpu_rst_n, 0);
    check({tag, " flags cleared"}, {done, cksum_err}, 0);
    sum = 8'h00;
    ck  = 8'h00;
    for (int i = 0; i < v.nbytes; i++) begin
      b = v.ramp ? 8'(8'h10 + i) : 8'($urandom);
      bytes.push_back(b);
      sum = 8'(sum + b);
      send_byte(b);
    end
    if (v.send_ck) begin
      ck = 8'(8'h00 - sum);
      if (!v.ck_good) ck = ck ^ (v.ramp ? 8'h88 : 8'($urandom_range(1, 255)));
      send_byte(ck);
    end else begin
      load_req = 1'b0;
      tick(SYNC_STAGES + 3);
    end
    check({tag, " done"}, done, v.exp_done);
    check({tag, " cksum_err"}, cksum_err, v.exp_err);
    check({tag, " busy after"}, busy, 0);
    check({tag, " write count"}, got_wr.size(), v.exp_we);
    for (int i = 0; i < got_wr.size() && i < bytes.size(); i++) begin
      check($sformatf("%s wr%0d addr", tag, i), got_wr[i].addr, i);
      check($sformatf("%s wr%0d data", tag, i), got_wr[i].data, bytes[i]);
    end
    check({tag, " ack toggles"}, ack_toggles, v.exp_ack);
    check({tag, " cpu held before release"}, cpu_rst_n, 0);
    if (v.send_ck) begin
      load_req = 1'b0;
      tick(SYNC_STAGES + 2);
      check({tag, " cpu release"}, cpu_rst_n, v.exp_done);
    end else begin
      got_wr.delete();
      a = ack_toggles;
      send_byte(8'h5A);
      check({tag, " err strobe no write"}, got_wr.size(), 0);
      check({tag, " err strobe no ack"}, ack_toggles, a);
      check({tag, " err cpu held"}, cpu_rst_n, 0);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   first_k;
    int   n_we;

    vecs[0] = '{1, 16, 1, 1, 1, 0, 16, 17};
    vecs[1] = '{1, 16, 1, 0, 0, 1, 16, 17};
    vecs[2] = '{1, 16, 1, 1, 1, 0, 16, 17};
    vecs[3] = '{0, 5,  0, 0, 0, 1, 5,  5 };
    vecs[4] = '{0, 0,  0, 0, 0, 1, 0,  0 };
    vecs[5] = '{0, 16, 0, 0, 0, 1, 16, 16};
    vecs[6] = '{0, 15, 0, 0, 0, 1, 15, 15};
    vecs[7] = '{0, 16, 1, 1, 1, 0, 16, 17};

    // Reset
    rst      = 1'b1;
    load_req = 1'b0;
    strobe   = 1'b0;
    data_in  = 8'h00;
    tick(3);
    check("reset outputs", {ram_addr, ram_data, ram_we, cpu_rst_n, busy, done, cksum_err, ack}, 0);
    rst = 1'b0;
    tick(1);
    check("post-reset cpu_rst_n", cpu_rst_n, 1);
    check("post-reset busy", busy, 0);

    // Strobe while idle is ignored
    got_wr.delete();
    ack_toggles = 0;
    send_byte(8'hAA);
    check("idle strobe no write", got_wr.size(), 0);
    check("idle strobe no ack", ack_toggles, 0);
    check("idle cpu running", cpu_rst_n, 1);

    // Held strobe: one accept, fixed latency
    load_req = 1'b1;
    tick(SYNC_STAGES + 3);
    check("held busy", busy, 1);
    got_wr.delete();
    data_in = 8'h3C;
    tick(1);
    strobe  = 1'b1;
    first_k = 0;
    n_we    = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (ram_we === 1'b1) begin
        n_we++;
        if (first_k == 0) first_k = k;
      end
    end
    strobe = 1'b0;
    tick(4);
    check("held we count", n_we, 1);
    check("held we latency", first_k, SYNC_STAGES + 1);
    check("held write count", got_wr.size(), 1);
    if (got_wr.size() > 0) begin
      check("held addr", got_wr[0].addr, 0);
      check("held data", got_wr[0].data, 8'h3C);
    end
    load_req = 1'b0;
    tick(SYNC_STAGES + 3);
    check("held abort err", cksum_err, 1);
    check("held abort busy", busy, 0);

    // Table-driven sessions
    for (int i = 0; i < 8; i++) run_load($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous load_req and strobe rise in idle
    tick(2);
    check("simul idle", cpu_rst_n, 1);
    got_wr.delete();
    ack_toggles = 0;
    data_in = 8'h77;
    tick(1);
    load_req = 1'b1;
    strobe   = 1'b1;
    tick(SYNC_STAGES + 3);
    strobe = 1'b0;
    tick(SYNC_STAGES + 3);
    check("simul busy", busy, 1);
    check("simul no write", got_wr.size(), 0);
    check("simul no ack", ack_toggles, 0);
    send_byte(8'h42);
    check("simul next write count", got_wr.size(), 1);
    if (got_wr.size() > 0) begin
      check("simul next addr", got_wr[0].addr, 0);
      check("simul next data", got_wr[0].data, 8'h42);
    end
    load_req = 1'b0;
    tick(SYNC_STAGES + 3);
    check("simul abort err", cksum_err, 1);

    // Random sessions
    for (int i = 0; i < 12; i++) run_load($sformatf("rand%0d", i), make_random());

    // Reset in the middle of a load
    load_req = 1'b0;
    tick(SYNC_STAGES + 4);
    load_req = 1'b1;
    tick(SYNC_STAGES + 3);
    for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i));
    rst      = 1'b1;
    load_req = 1'b0;
    tick(2);
    check("midrst cpu held", cpu_rst_n, 0);
    rst = 1'b0;
    tick(1);
    check("midrst cpu released", cpu_rst_n, 1);
    check("midrst busy", busy, 0);
    check("midrst flags", {done, cksum_err}, 0);
    tick(6);
    check("midrst stays idle", cpu_rst_n, 1);

    check("single-cycle we pulses", we_double, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
